// File: rtl/apb_uart_pkg.sv
// Shared constants for the APB UART register block: register addresses,
// STATUS/CTRL bit positions and the TX launch state encoding.
package apb_uart_pkg;

    localparam logic [4:0] ADDR_TXDATA = 5'h00;
    localparam logic [4:0] ADDR_RXDATA = 5'h04;
    localparam logic [4:0] ADDR_STATUS = 5'h08;
    localparam logic [4:0] ADDR_CTRL   = 5'h0C;
    localparam logic [4:0] ADDR_BAUD   = 5'h10;

    localparam int ST_RX_NOT_EMPTY = 0;
    localparam int ST_RX_FULL      = 1;
    localparam int ST_OVERRUN      = 2;
    localparam int ST_HOLD_VALID   = 3;
    localparam int ST_TX_ACTIVE    = 4;

    localparam int CTRL_TX_EN = 0;
    localparam int CTRL_RX_EN = 1;
    localparam int CTRL_IE_RX = 2;
    localparam int CTRL_IE_TX = 3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_BUSY  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/apb_uart_rx_fifo.sv
// Small RX byte FIFO. A pop is ignored when empty; a push is dropped when
// full unless a pop happens on the same edge, which frees the slot.
module apb_uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];
    assign count   = cnt;

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible through count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/apb_uart_regs.sv
// APB3 register front end for the UART core: TX holding register with a
// launch FSM, RX capture FIFO, control/baud registers and the interrupt.
// APB handshake: zero wait states, PREADY is tied high; a transfer takes
// effect on the edge where PSEL & PENABLE are both high, and PRDATA/PSLVERR
// are combinational and valid only during that access phase.
module apb_uart_regs
    import apb_uart_pkg::*;
#(
    parameter int BAUD_DEFAULT = 868,
    parameter int RX_DEPTH     = 4,
    parameter int BAUD_W       = 20
) (
    input  logic              PCLK,
    input  logic              rst,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [4:0]        PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              uart_tx_en,
    output logic [7:0]        uart_tx_data,
    input  logic              uart_tx_busy,
    input  logic              uart_tx_done,
    output logic              uart_rx_en,
    input  logic [7:0]        uart_rx_data,
    input  logic              uart_rx_done,
    output logic [BAUD_W-1:0] baud_div,
    output logic              irq
);
    localparam int CW = $clog2(RX_DEPTH) + 1;

    tx_state_t   tx_state;
    logic [7:0]  hold;
    logic        hold_valid;
    logic [3:0]  ctrl;
    logic        overrun;
    logic        rx_done_q;

    logic        acc;
    logic [4:0]  addr;
    logic        launch;
    logic        rx_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic [7:0]  status;

    logic [31:0] prdata_c;
    logic        slverr_c;
    logic        hold_wr;
    logic        ctrl_wr;
    logic        baud_wr;
    logic        ovr_clr;
    logic        ovr_set;
    logic        unused_bits;

    assign acc     = PSEL & PENABLE;
    assign addr    = {PADDR[4:2], 2'b00};
    assign launch  = (tx_state == TX_IDLE) & hold_valid & ctrl[CTRL_TX_EN] & ~uart_tx_busy;
    assign rx_push = ctrl[CTRL_RX_EN] & uart_rx_done & ~rx_done_q;
    assign ovr_set = rx_push & fifo_full & ~fifo_pop;
    assign status  = {3'(fifo_count), (tx_state != TX_IDLE), hold_valid, overrun,
                      fifo_full, ~fifo_empty};

    assign PREADY      = 1'b1;
    assign PRDATA      = prdata_c;
    assign PSLVERR     = slverr_c;
    assign uart_rx_en  = ctrl[CTRL_RX_EN];
    assign unused_bits = ^{PADDR[1:0], PWDATA};

    apb_uart_rx_fifo #(.DEPTH(RX_DEPTH), .W(8)) u_rx_fifo (
        .clk   (PCLK),
        .rst   (rst),
        .push  (rx_push),
        .pop   (fifo_pop),
        .wdata (uart_rx_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Address decode: read data, error response and write strobes.
    always_comb begin
        prdata_c = '0;
        slverr_c = 1'b0;
        hold_wr  = 1'b0;
        ctrl_wr  = 1'b0;
        baud_wr  = 1'b0;
        ovr_clr  = 1'b0;
        fifo_pop = 1'b0;
        if (acc) begin
            case (addr)
                ADDR_TXDATA: begin
                    // A write racing the launch that empties hold is accepted.
                    if (PWRITE) begin
                        if (hold_valid & ~launch) slverr_c = 1'b1;
                        else                      hold_wr  = 1'b1;
                    end
                end
                ADDR_RXDATA: begin
                    if (PWRITE || fifo_empty) begin
                        slverr_c = 1'b1;
                    end else begin
                        prdata_c = {24'b0, fifo_rdata};
                        fifo_pop = 1'b1;
                    end
                end
                ADDR_STATUS: begin
                    if (PWRITE) ovr_clr  = PWDATA[ST_OVERRUN];
                    else        prdata_c = {24'b0, status};
                end
                ADDR_CTRL: begin
                    if (PWRITE) ctrl_wr  = 1'b1;
                    else        prdata_c = {28'b0, ctrl};
                end
                ADDR_BAUD: begin
                    if (PWRITE) begin
                        if (PWDATA[BAUD_W-1:0] == '0) slverr_c = 1'b1;
                        else                          baud_wr  = 1'b1;
                    end else begin
                        prdata_c = 32'(baud_div);
                    end
                end
                default: slverr_c = 1'b1;
            endcase
        end
    end

    // Software-visible registers, sticky overrun and the registered interrupt.
    always_ff @(posedge PCLK) begin
        if (rst) begin
            hold       <= '0;
            hold_valid <= 1'b0;
            ctrl       <= '0;
            baud_div   <= BAUD_W'(BAUD_DEFAULT);
            overrun    <= 1'b0;
            rx_done_q  <= 1'b0;
            irq        <= 1'b0;
        end else begin
            rx_done_q <= uart_rx_done;
            if (hold_wr) begin
                hold       <= PWDATA[7:0];
                hold_valid <= 1'b1;
            end else if (launch) begin
                hold_valid <= 1'b0;
            end
            if (ctrl_wr) ctrl     <= PWDATA[3:0];
            if (baud_wr) baud_div <= PWDATA[BAUD_W-1:0];
            overrun <= ovr_set | (overrun & ~ovr_clr);
            irq <= (ctrl[CTRL_IE_RX] & (~fifo_empty | overrun)) |
                   (ctrl[CTRL_IE_TX] & ~hold_valid & (tx_state == TX_IDLE));
        end
    end

    // TX launch FSM: present hold to the core until it reports busy, then
    // wait for the frame to finish before allowing the next launch.
    always_ff @(posedge PCLK) begin
        if (rst) begin
            tx_state     <= TX_IDLE;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (launch) begin
                        uart_tx_data <= hold;
                        uart_tx_en   <= 1'b1;
                        tx_state     <= TX_START;
                    end
                end
                TX_START: begin
                    if (uart_tx_busy) begin
                        uart_tx_en <= 1'b0;
                        tx_state   <= TX_BUSY;
                    end
                end
                TX_BUSY: begin
                    if (uart_tx_done && !uart_tx_busy) tx_state <= TX_IDLE;
                end
                default: begin
                    uart_tx_en <= 1'b0;
                    tx_state   <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_uart_regs.sv
// Directed bench for apb_uart_regs with a simple UART TX core model.
module tb_apb_uart_regs;
    import apb_uart_pkg::*;

    logic        PCLK = 1'b0;
    logic        rst;
    logic        PSEL, PENABLE, PWRITE;
    logic [4:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic        uart_tx_en;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_busy, uart_tx_done;
    logic        uart_rx_en;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_done;
    logic [19:0] baud_div;
    logic        irq;

    int total = 0;
    int bad   = 0;

    apb_uart_regs dut (
        .PCLK(PCLK), .rst(rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data),
        .uart_tx_busy(uart_tx_busy), .uart_tx_done(uart_tx_done),
        .uart_rx_en(uart_rx_en), .uart_rx_data(uart_rx_data),
        .uart_rx_done(uart_rx_done), .baud_div(baud_div), .irq(irq)
    );

    // Clock and reset
    always #5 PCLK = ~PCLK;

    // UART TX core model: busy rises two cycles after a launch request,
    // stays up four cycles, then done pulses for one cycle.
    initial begin
        uart_tx_busy = 1'b0;
        uart_tx_done = 1'b0;
        forever begin
            @(negedge PCLK);
            if (uart_tx_en && !uart_tx_busy) begin
                repeat (2) @(negedge PCLK);
                uart_tx_busy = 1'b1;
                repeat (4) @(negedge PCLK);
                uart_tx_busy = 1'b0;
                uart_tx_done = 1'b1;
                @(negedge PCLK);
                uart_tx_done = 1'b0;
            end
        end
    end

    // Driver: one APB transfer, optionally raising rx_done in the access phase.
    task automatic apb_xfer(input logic wr, input logic [4:0] a, input logic [31:0] wd,
                            input logic rx_edge, input logic [7:0] rxd,
                            output logic [31:0] rd, output logic err);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        if (rx_edge) begin
            uart_rx_data = rxd;
            uart_rx_done = 1'b1;
        end
        #1;
        rd  = PRDATA;
        err = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        uart_rx_done = 1'b0;
    endtask

    task automatic apb_write(input logic [4:0] a, input logic [31:0] wd, output logic err);
        logic [31:0] d;
        apb_xfer(1'b1, a, wd, 1'b0, 8'h00, d, err);
    endtask

    task automatic apb_read(input logic [4:0] a, output logic [31:0] d, output logic err);
        apb_xfer(1'b0, a, 32'h0, 1'b0, 8'h00, d, err);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(posedge PCLK); #1;
        uart_rx_data = b; uart_rx_done = 1'b1;
        @(posedge PCLK); #1;
        uart_rx_done = 1'b0;
        @(posedge PCLK); #1;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e;
        total++; if (PREADY !== 1'b1) begin bad++; $display("FAIL reset_pready got=%b exp=1", PREADY); end
        total++; if (PRDATA !== 32'h0) begin bad++; $display("FAIL reset_prdata got=%h exp=0", PRDATA); end
        total++; if (uart_tx_en !== 1'b0 || uart_rx_en !== 1'b0 || irq !== 1'b0) begin
            bad++; $display("FAIL reset_outs got=%b%b%b exp=000", uart_tx_en, uart_rx_en, irq); end
        total++; if (baud_div !== 20'd868) begin bad++; $display("FAIL reset_baud_div got=%0d exp=868", baud_div); end
        apb_read(ADDR_BAUD, d, e);
        total++; if (d !== 32'd868 || e !== 1'b0) begin bad++; $display("FAIL reset_baud_rd got=%h/%b exp=364/0", d, e); end
        apb_read(ADDR_CTRL, d, e);
        total++; if (d !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL reset_ctrl_rd got=%h/%b exp=0/0", d, e); end
        apb_read(ADDR_STATUS, d, e);
        total++; if (d !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL reset_status_rd got=%h/%b exp=0/0", d, e); end
    endtask

    task automatic test_tx();
        logic [31:0] d; logic e; int cnt;
        apb_write(ADDR_CTRL, 32'h1, e);
        apb_write(ADDR_TXDATA, 32'hB3, e);
        total++; if (e !== 1'b0) begin bad++; $display("FAIL tx_wr_err got=%b exp=0", e); end
        cnt = 0;
        while (!uart_tx_en && cnt < 10) begin @(posedge PCLK); #1; cnt++; end
        total++; if (uart_tx_en !== 1'b1 || uart_tx_data !== 8'hB3) begin
            bad++; $display("FAIL tx_launch got=%b/%h exp=1/b3", uart_tx_en, uart_tx_data); end
        cnt = 0;
        while (uart_tx_en && cnt < 20) begin cnt++; @(posedge PCLK); #1; end
        total++; if (cnt != 3 || uart_tx_busy !== 1'b1) begin
            bad++; $display("FAIL tx_en_width got=%0d/%b exp=3/1", cnt, uart_tx_busy); end
        apb_read(ADDR_STATUS, d, e);
        total++; if (d !== 32'h10) begin bad++; $display("FAIL tx_active_status got=%h exp=10", d); end
        apb_write(ADDR_CTRL, 32'h0, e);
        apb_write(ADDR_TXDATA, 32'h5A, e);
        total++; if (e !== 1'b0) begin bad++; $display("FAIL tx_hold_load got=%b exp=0", e); end
        apb_write(ADDR_TXDATA, 32'h77, e);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL tx_hold_full_err got=%b exp=1", e); end
        repeat (3) @(posedge PCLK); #1;
        total++; if (uart_tx_en !== 1'b0) begin bad++; $display("FAIL tx_blocked got=%b exp=0", uart_tx_en); end
        apb_read(ADDR_STATUS, d, e);
        total++; if (d !== 32'h08) begin bad++; $display("FAIL tx_hold_status got=%h exp=08", d); end
        apb_write(ADDR_CTRL, 32'h1, e);
        cnt = 0;
        while (!uart_tx_en && cnt < 10) begin @(posedge PCLK); #1; cnt++; end
        total++; if (uart_tx_en !== 1'b1 || uart_tx_data !== 8'h5A) begin
            bad++; $display("FAIL tx_second_launch got=%b/%h exp=1/5a", uart_tx_en, uart_tx_data); end
        repeat (20) @(posedge PCLK); #1;
        apb_read(ADDR_STATUS, d, e);
        total++; if (d !== 32'h00) begin bad++; $display("FAIL tx_done_status got=%h exp=00", d); end
        apb_write(ADDR_CTRL, 32'h0, e);
    endtask

    task automatic test_rx_overrun();
        logic [31:0] d; logic e;
        logic [7:0] bytes [5];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        apb_write(ADDR_CTRL, 32'h2, e);
        total++; if (uart_rx_en !== 1'b1) begin bad++; $display("FAIL rx_en got=%b exp=1", uart_rx_en); end
        for (int i = 0; i < 5; i++) rx_byte(bytes[i]);
        apb_read(ADDR_STATUS, d, e);
        total++; if (d !== 32'h87) begin bad++; $display("FAIL rx_full_status got=%h exp=87", d); end
        for (int i = 0; i < 4; i++) begin
            apb_read(ADDR_RXDATA, d, e);
            total++; if (d !== {24'b0, bytes[i]} || e !== 1'b0) begin
                bad++; $display("FAIL rx_read%0d got=%h/%b exp=%h/0", i, d, e, bytes[i]); end
        end
        apb_read(ADDR_RXDATA, d, e);
        total++; if (d !== 32'h0 || e !== 1'b1) begin bad++; $display("FAIL rx_empty_read got=%h/%b exp=0/1", d, e); end
        apb_read(ADDR_STATUS, d, e);
        total++; if (d !== 32'h04) begin bad++; $display("FAIL rx_sticky_ovr got=%h exp=04", d); end
        apb_write(ADDR_STATUS, 32'h4, e);
        apb_read(ADDR_STATUS, d, e);
        total++; if (d !== 32'h00) begin bad++; $display("FAIL rx_w1c got=%h exp=00", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic e;
        for (int i = 0; i < 4; i++) rx_byte(8'hA1 + 8'(i));
        apb_read(ADDR_STATUS, d, e);
        total++; if (d !== 32'h83) begin bad++; $display("FAIL b2b_full got=%h exp=83", d); end
        apb_xfer(1'b0, ADDR_RXDATA, 32'h0, 1'b1, 8'hA5, d, e);
        total++; if (d !== 32'hA1 || e !== 1'b0) begin bad++; $display("FAIL b2b_pushpop got=%h/%b exp=a1/0", d, e); end
        apb_read(ADDR_STATUS, d, e);
        total++; if (d !== 32'h83) begin bad++; $display("FAIL b2b_count got=%h exp=83", d); end
        for (int i = 0; i < 4; i++) begin
            apb_read(ADDR_RXDATA, d, e);
            total++; if (d !== 32'hA2 + i) begin bad++; $display("FAIL b2b_drain%0d got=%h exp=%h", i, d, 32'hA2 + i); end
        end
        apb_xfer(1'b0, ADDR_RXDATA, 32'h0, 1'b1, 8'hC7, d, e);
        total++; if (d !== 32'h0 || e !== 1'b1) begin bad++; $display("FAIL b2b_empty_pop got=%h/%b exp=0/1", d, e); end
        apb_read(ADDR_STATUS, d, e);
        total++; if (d !== 32'h21) begin bad++; $display("FAIL b2b_empty_push got=%h exp=21", d); end
        apb_read(ADDR_RXDATA, d, e);
        total++; if (d !== 32'hC7) begin bad++; $display("FAIL b2b_c7 got=%h exp=c7", d); end
        for (int i = 0; i < 4; i++) rx_byte(8'hD0 + 8'(i));
        apb_xfer(1'b1, ADDR_STATUS, 32'h4, 1'b1, 8'hDF, d, e);
        apb_read(ADDR_STATUS, d, e);
        total++; if (d !== 32'h87) begin bad++; $display("FAIL b2b_w1c_vs_set got=%h exp=87", d); end
        for (int i = 0; i < 4; i++) apb_read(ADDR_RXDATA, d, e);
        apb_write(ADDR_STATUS, 32'h4, e);
    endtask

    task automatic test_misc();
        logic [31:0] d; logic e;
        apb_write(ADDR_BAUD, 32'h0, e);
        total++; if (e !== 1'b1 || baud_div !== 20'd868) begin
            bad++; $display("FAIL baud_zero got=%b/%0d exp=1/868", e, baud_div); end
        apb_write(ADDR_BAUD, 32'd1000, e);
        total++; if (e !== 1'b0 || baud_div !== 20'd1000) begin
            bad++; $display("FAIL baud_set got=%b/%0d exp=0/1000", e, baud_div); end
        apb_read(5'h14, d, e);
        total++; if (d !== 32'h0 || e !== 1'b1) begin bad++; $display("FAIL bad_addr got=%h/%b exp=0/1", d, e); end
        apb_write(ADDR_RXDATA, 32'h12, e);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL rxdata_write got=%b exp=1", e); end
        apb_read(ADDR_TXDATA, d, e);
        total++; if (d !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL txdata_read got=%h/%b exp=0/0", d, e); end
    endtask

    task automatic test_irq();
        logic [31:0] d; logic e;
        apb_write(ADDR_CTRL, 32'h4, e);
        @(posedge PCLK); #1;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_rx_idle got=%b exp=0", irq); end
        apb_write(ADDR_CTRL, 32'hC, e);
        @(posedge PCLK); #1;
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_tx_src got=%b exp=1", irq); end
        apb_write(ADDR_CTRL, 32'hE, e);
        rx_byte(8'h66);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_rx_tx got=%b exp=1", irq); end
        apb_read(ADDR_RXDATA, d, e);
        apb_write(ADDR_TXDATA, 32'h99, e);
        @(posedge PCLK); #1;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear got=%b exp=0", irq); end
        rx_byte(8'h67);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_rx_src got=%b exp=1", irq); end
        apb_read(ADDR_RXDATA, d, e);
        @(posedge PCLK); #1;
        total++; if (irq !== 1'b0 || d !== 32'h67) begin
            bad++; $display("FAIL irq_rx_pop got=%b/%h exp=0/67", irq, d); end
    endtask

    initial begin
        rst = 1'b1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        uart_rx_data = '0; uart_rx_done = 1'b0;
        repeat (3) @(posedge PCLK);
        #1 rst = 1'b0;
        test_reset();
        test_tx();
        test_rx_overrun();
        test_back_to_back();
        test_misc();
        test_irq();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
